// File: rtl/ad9467_pkg.sv
// Shared types and helpers for the AD9467-style DDR byte interface.
package ad9467_pkg;

    localparam int unsigned ADC_BYTE_W   = 8;
    localparam int unsigned ADC_WORD_W   = 16;
    localparam int unsigned CLK_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4
    } tx_state_t;

    // odd=0 gathers bits 0,2,..,14; odd=1 gathers bits 1,3,..,15
    function automatic logic [ADC_BYTE_W-1:0] bit_split(
        input logic [ADC_WORD_W-1:0] word,
        input logic                  odd
    );
        logic [ADC_BYTE_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < ADC_BYTE_W; i++) begin
            b[i] = odd ? word[2*i+1] : word[2*i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ad9467_ddr_tx_sync_fifo.sv
// Single-clock FIFO with registered occupancy; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      level <= level + 1'b1;
            else if (rd_en && !wr_en) level <= level - 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ad9467_ddr_tx.sv
// DDR byte transmitter: 16-bit words out as even/odd bytes with a sclk/4 dco strobe.
module ad9467_ddr_tx
    import ad9467_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [15:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          underflow_clr,
    output logic [7:0]                    data_out,
    output logic                          dco,
    output logic                          underflow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    tx_state_t       state_q, state_d;
    logic [15:0]     cur_word;
    logic [15:0]     fifo_head;
    logic [15:0]     fetch_word;
    logic            fifo_full, fifo_empty;
    logic            fetch;
    logic            wr_en, rd_en;
    logic [7:0]      data_d;
    logic            dco_d;

    assign s_ready    = !fifo_full;
    assign wr_en      = s_valid && s_ready;
    assign rd_en      = fetch && !fifo_empty;
    assign fetch_word = fifo_empty ? IDLE_WORD : fifo_head;
    assign busy       = (state_q != IDLE);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADC_WORD_W)
    ) u_fifo (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Output values are those of the state being entered, so they are valid for its whole cycle.
    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        data_d  = data_out;
        dco_d   = dco;
        unique case (state_q)
            IDLE: begin
                data_d = '0;
                dco_d  = 1'b0;
                if (en) begin
                    fetch   = 1'b1;
                    state_d = P0;
                    data_d  = bit_split(fetch_word, 1'b0);
                end
            end
            P0: begin
                state_d = P1;
                dco_d   = 1'b1;
            end
            P1: begin
                state_d = P2;
                data_d  = bit_split(cur_word, 1'b1);
                dco_d   = 1'b1;
            end
            P2: begin
                state_d = P3;
                dco_d   = 1'b0;
            end
            P3: begin
                dco_d = 1'b0;
                if (en) begin
                    fetch   = 1'b1;
                    state_d = P0;
                    data_d  = bit_split(fetch_word, 1'b0);
                end else begin
                    state_d = IDLE;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
                dco_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            dco       <= 1'b0;
            cur_word  <= '0;
            underflow <= 1'b0;
        end else begin
            data_out <= data_d;
            dco      <= dco_d;
            if (fetch) cur_word <= fetch_word;
            if (fetch && (state_q == P3) && fifo_empty) underflow <= 1'b1;
            else if (underflow_clr)                     underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad9467_ddr_tx.sv
// Directed + randomized bench for ad9467_ddr_tx against a queue-based slot model.
module tb_ad9467_ddr_tx;

    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] IDLE_W = 16'h0000;

    logic        sclk, rst_n, en, s_valid, s_ready, underflow_clr;
    logic [15:0] s_data;
    logic [7:0]  data_out;
    logic        dco, underflow, busy;
    logic [2:0]  fifo_level;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: pending words, current word, position within the 4-cycle word slot (-1 = idle)
    logic [15:0] m_q [$];
    logic [15:0] m_word;
    int          m_phase;
    logic        m_ul;

    ad9467_ddr_tx #(
        .FIFO_DEPTH (DEPTH),
        .IDLE_WORD  (IDLE_W)
    ) dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .en            (en),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .underflow_clr (underflow_clr),
        .data_out      (data_out),
        .dco           (dco),
        .underflow     (underflow),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic logic [7:0] ref_byte(input logic [15:0] w, input int hi);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[2*i+hi];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_word  = '0;
        m_phase = -1;
        m_ul    = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic v, input logic [15:0] d, input logic c);
        bit wr, fetch, ul_set;
        wr     = v && (m_q.size() < DEPTH);
        fetch  = e && (m_phase == -1 || m_phase == 3);
        ul_set = 1'b0;
        if (fetch) begin
            if (m_q.size() > 0) m_word = m_q.pop_front();
            else begin
                m_word = IDLE_W;
                ul_set = (m_phase == 3);
            end
        end
        if (ul_set)  m_ul = 1'b1;
        else if (c)  m_ul = 1'b0;
        if (wr) m_q.push_back(d);
        if (fetch)              m_phase = 0;
        else if (m_phase == 3)  m_phase = -1;
        else if (m_phase >= 0)  m_phase = m_phase + 1;
    endtask

    task automatic check_model();
        logic [7:0] exp_d;
        if (m_phase < 0)      exp_d = 8'h00;
        else if (m_phase < 2) exp_d = ref_byte(m_word, 0);
        else                  exp_d = ref_byte(m_word, 1);
        chk("data_out",   {8'h00, data_out},   {8'h00, exp_d});
        chk("dco",        {15'd0, dco},        {15'd0, (m_phase == 1 || m_phase == 2)});
        chk("busy",       {15'd0, busy},       {15'd0, (m_phase != -1)});
        chk("underflow",  {15'd0, underflow},  {15'd0, m_ul});
        chk("s_ready",    {15'd0, s_ready},    {15'd0, (m_q.size() < DEPTH)});
        chk("fifo_level", {13'd0, fifo_level}, 16'(m_q.size()));
    endtask

    task automatic step(input logic e, input logic v, input logic [15:0] d, input logic c);
        en = e; s_valid = v; s_data = d; underflow_clr = c;
        @(posedge sclk);
        model_edge(e, v, d, c);
        #1;
        check_model();
        @(negedge sclk);
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_data"},  {8'h00, data_out},   16'h0000);
        chk({tag, "_dco"},   {15'd0, dco},        16'h0000);
        chk({tag, "_rdy"},   {15'd0, s_ready},    16'h0001);
        chk({tag, "_lvl"},   {13'd0, fifo_level}, 16'h0000);
        chk({tag, "_ufl"},   {15'd0, underflow},  16'h0000);
        chk({tag, "_busy"},  {15'd0, busy},       16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; underflow_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge sclk);
        #1 check_reset_now("rst0");
        @(negedge sclk);
        rst_n = 1'b1;

        // Single word A5C3: 39/39/C9/C9, then idle word with underflow
        step(1'b0, 1'b1, 16'hA5C3, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("a5c3_p0", {7'd0, dco, data_out}, 16'h0039);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("a5c3_p1", {7'd0, dco, data_out}, 16'h0139);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("a5c3_p2", {7'd0, dco, data_out}, 16'h01C9);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("a5c3_p3", {7'd0, dco, data_out}, 16'h00C9);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("idle_word_ufl", {7'd0, underflow, data_out}, 16'h0100);
        repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("back_idle", {15'd0, busy}, 16'h0000);

        // Clear in a later cycle, then set and clear together (set wins)
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("ufl_cleared", {15'd0, underflow}, 16'h0000);
        repeat (4) step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("idle_fetch_no_ufl", {15'd0, underflow}, 16'h0000);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("set_wins", {15'd0, underflow}, 16'h0001);
        repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("clr_later", {15'd0, underflow}, 16'h0000);

        // Back-to-back words with continuous dco
        step(1'b0, 1'b1, 16'h5555, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        repeat (12) step(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // Fill with en low, then drain
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'(16'h1000 + i), 1'b0);
        chk("fill_level", {13'd0, fifo_level}, 16'd4);
        chk("fill_ready", {15'd0, s_ready}, 16'h0000);
        repeat (18) step(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // Drop en during P1 of 1234: H byte still sent, then idle
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("drop_en_p3", {7'd0, dco, data_out}, {8'h00, ref_byte(16'h1234, 1)});
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("drop_en_idle", {7'd0, busy, dco, data_out[6:0]}, 16'h0000);

        // Asynchronous reset mid-word with words queued
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        step(1'b0, 1'b1, 16'hCAFE, 1'b0);
        step(1'b1, 1'b1, 16'h7777, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_now("rst_mid");
        model_reset();
        @(negedge sclk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                 16'($urandom()), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
